// File: rtl/data_memory_if.sv
// Execute-to-DM stage bus: execute result, store data and access controls in,
// registered stage result out. The master is the pipeline side; the slave is
// the data-memory stage.
interface data_memory_if;
  logic [15:0] ans_ex;          // address and pass-through value
  logic [15:0] DM_data;         // store data
  logic        mem_rw_ex;       // 1 = write, 0 = read
  logic        mem_en_ex;       // memory access enable
  logic        mem_mux_sel_dm;  // 1 = memory word, 0 = ans_ex
  logic [15:0] ans_dm;          // registered stage result

  modport master (
    output ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
    input  ans_dm
  );

  modport slave (
    input  ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
    output ans_dm
  );
endinterface

// File: rtl/data_memory.sv
// Data-memory stage of the 16-bit MIPS pipeline: a word-addressed RAM of
// 2^ADDR_W 16-bit words, plus a pass-through of the execute result. The
// selected value is registered onto ans_dm for write-back.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-low; clears ans_dm and every RAM word
//   dm    - slave side of data_memory_if (ans_ex, DM_data, mem_rw_ex,
//           mem_en_ex, mem_mux_sel_dm in; ans_dm out)
module data_memory #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave dm
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       ans_q;
  logic [ADDR_W-1:0] addr;

  // Upper bits of ans_ex are dropped, so addresses wrap modulo DEPTH.
  assign addr = dm.ans_ex[ADDR_W-1:0];

  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = &{1'b0, dm.ans_ex[15:ADDR_W]};
    end
  endgenerate

  // Read-before-write: nonblocking update means a write cycle returns the
  // word that was stored before this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ans_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (dm.mem_en_ex && dm.mem_rw_ex) begin
        mem[addr] <= dm.DM_data;
      end
      if (!dm.mem_mux_sel_dm) begin
        ans_q <= dm.ans_ex;
      end else if (dm.mem_en_ex) begin
        ans_q <= mem[addr];
      end
    end
  end

  assign dm.ans_dm = ans_q;
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed steps followed by random traffic, checked
// against an array-based model of the RAM and the output register.
module tb_data_memory;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_memory_if dm ();

  data_memory #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dm    (dm.slave)
  );

  logic [15:0] ref_mem [256];
  logic [15:0] ref_ans;
  int vectors     = 0;
  int miscompares = 0;

  // Drive one cycle's inputs, take one rising edge, update the model, and
  // leave time 1 ns past the edge for sampling.
  task automatic apply(input logic rst, input logic [15:0] ans, input logic [15:0] data,
                       input logic rw, input logic en, input logic sel);
    logic [7:0]  a;
    logic [15:0] old_word;
    reset             = rst;
    dm.ans_ex         = ans;
    dm.DM_data        = data;
    dm.mem_rw_ex      = rw;
    dm.mem_en_ex      = en;
    dm.mem_mux_sel_dm = sel;
    @(posedge clk);
    a = ans[7:0];
    if (!rst) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      ref_ans = 16'h0000;
    end else begin
      old_word = ref_mem[a];
      if (en && rw) ref_mem[a] = data;
      if (!sel) ref_ans = ans;
      else if (en) ref_ans = old_word;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] expected);
    vectors++;
    assert (dm.ans_dm === expected) else begin
      miscompares++;
      $error("FAIL %s: ans_dm=%h expected=%h", tag, dm.ans_dm, expected);
    end
  endtask

  initial begin
    reset             = 1'b1;
    dm.ans_ex         = '0;
    dm.DM_data        = '0;
    dm.mem_rw_ex      = 1'b0;
    dm.mem_en_ex      = 1'b0;
    dm.mem_mux_sel_dm = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    ref_ans = 16'h0000;
    #2;

    // Reset clears nonzero state
    apply(1'b0, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1);
    check("init_reset", 16'h0000);
    apply(1'b1, 16'h0003, 16'h7777, 1'b1, 1'b1, 1'b0);
    check("preload_pass", 16'h0003);
    apply(1'b0, 16'h0055, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("reset_clear", 16'h0000);
    apply(1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("read_after_reset", 16'h0000);

    // Read, write, read on address 3
    apply(1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    check("rwr_read0", 16'h0000);
    apply(1'b1, 16'h0003, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    check("rwr_write_old", 16'h0000);
    apply(1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    check("rwr_read_new", 16'hFFFF);

    // Pass-through with enable off and with a write
    apply(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("pass_en0", 16'h1234);
    apply(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0);
    check("pass_write", 16'h1234);
    apply(1'b1, 16'h0034, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("pass_write_rb", 16'h4321);

    // Hold with memory disabled
    apply(1'b1, 16'h00AB, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("hold_setup", 16'h00AB);
    apply(1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("hold", 16'h00AB);
    apply(1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("hold_mem_kept", 16'hFFFF);

    // Address wrap
    apply(1'b1, 16'h0105, 16'h5A5A, 1'b1, 1'b1, 1'b1);
    check("wrap_write_old", 16'h0000);
    apply(1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("wrap_read", 16'h5A5A);

    // Reset beats a simultaneous write
    apply(1'b0, 16'h0007, 16'hBEEF, 1'b1, 1'b1, 1'b1);
    check("reset_vs_write", 16'h0000);
    apply(1'b1, 16'h0007, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("write_discarded", 16'h0000);
    apply(1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("mem_cleared", 16'h0000);

    // A reset pulse between edges is ignored
    apply(1'b1, 16'h0009, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    check("pulse_setup", 16'h0000);
    apply(1'b1, 16'h0009, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("pulse_pre", 16'hCAFE);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("pulse_no_clear_out", 16'hCAFE);
    apply(1'b1, 16'h0009, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("pulse_no_clear_mem", 16'hCAFE);

    // Random traffic over a small address window to force reuse
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ans;
      logic [31:0] r;
      r   = $urandom;
      ans = {r[31:24], 4'h0, r[3:0]};
      apply(($urandom_range(0, 49) != 0), ans, 16'($urandom), r[8], r[9] | r[10], r[11]);
      check("random", ref_ans);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Data-memory (DM) stage of the 16-bit MIPS pipeline. It takes the execute-stage result, and either accesses a word-addressed on-chip RAM or passes the result through. It registers the selected value onto `ans_dm` for the write-back stage. All state changes on the rising clock edge, including reset.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width; depth is 2^ADDR_W 16-bit words (256 by default).

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: clock; everything updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `ans_ex`, input, 16: execute-stage result; used as the memory word address and as the pass-through value.
- `DM_data`, input, 16: store data.
- `mem_rw_ex`, input, 1: access direction; 1 = write, 0 = read.
- `mem_en_ex`, input, 1: memory access enable.
- `mem_mux_sel_dm`, input, 1: output select; 1 = memory read word, 0 = `ans_ex` pass-through.
- `ans_dm`, output, 16: registered stage result.

## Operation
- Storage: array `mem[0 .. 2^ADDR_W-1]` of 16-bit words.
- Address `a` = `ans_ex[ADDR_W-1:0]`.
  - Upper bits of `ans_ex` are ignored, so addresses wrap modulo depth.
- Reset (`reset`=0 at a rising edge):
  - `ans_dm` <= 16'h0000.
  - Every `mem` word <= 16'h0000.
  - Reset takes priority: no write and no output update other than the clear happen in that cycle.
- Normal edge (`reset`=1):
  - Write: if `mem_en_ex`=1 and `mem_rw_ex`=1, then `mem[a]` <= `DM_data`.
  - Output: if `mem_mux_sel_dm`=0, then `ans_dm` <= `ans_ex`, regardless of enable or direction.
  - Output: if `mem_mux_sel_dm`=1 and `mem_en_ex`=1, then `ans_dm` <= `mem[a]` as it was before this edge (read-before-write). This applies to both read and write cycles, so a write cycle returns the old contents.
  - Output: if `mem_mux_sel_dm`=1 and `mem_en_ex`=0, then `ans_dm` holds its value.
- With `mem_en_ex`=0 the RAM is never modified.
- There is no handshake, no stall and no error signalling. Every input is sampled every cycle.

## Timing
- Write latency: `mem[a]` is updated at the edge where the write is sampled. A read of the same address on the next edge returns the new data.
- Read latency: 1 cycle. The word sampled at edge N appears on `ans_dm` right after edge N and stays until edge N+1.
- Pass-through latency: 1 cycle (`ans_dm` = `ans_ex` sampled at the previous edge).
- `ans_dm` is driven only from a register; there is no combinational path from any input to `ans_dm`.
- Reset mid-operation: a write presented in the same cycle that reset is low is discarded.
- Reset recovery: after reset is released, the first read of any address returns 16'h0000.
- Back-to-back accesses to the same or different addresses are allowed every cycle.

## Test plan
- Reset clears state: set `ans_dm`/memory to nonzero, hold `reset`=0 for one edge -> `ans_dm`=0000. Then read addr 3 with `mem_en_ex`=1, `mem_rw_ex`=0, `mem_mux_sel_dm`=1 -> `ans_dm`=0000.
- Read, write, read on one address: `ans_ex`=0003, `DM_data`=FFFF, en=1, sel=1.
  - rw=0 for one edge -> `ans_dm`=0000.
  - rw=1 for one edge -> `ans_dm`=0000 (old data) and `mem[3]`=FFFF.
  - rw=0 for one edge -> `ans_dm`=FFFF.
- Pass-through: sel=0, `ans_ex`=1234, with en=0 and then en=1/rw=1 -> `ans_dm`=1234 after each edge. The en=1/rw=1 case also writes `DM_data` to `mem[0x34]`.
- Hold and disable: sel=1, en=0, rw=1, `ans_dm` previously 00AB -> `ans_dm` stays 00AB and memory is unchanged (read back to confirm).
- Address wrap: write 5A5A at `ans_ex`=0105, then read at `ans_ex`=0005 -> `ans_dm`=5A5A.
- Synchronous reset vs. write: `reset`=0 together with en=1, rw=1, `DM_data`=BEEF at addr 7. Release reset and read addr 7 -> 0000. Also confirm that a `reset` pulse between edges has no effect.
